// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, constants and helpers for the mem_data arbiter.
package mem_arb_pkg;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_AUX  = 1'b1
  } port_id_t;

  localparam int unsigned MEM_ARB_NUM_PORTS = 2;

  // True when a 16-bit word address falls inside a 2**addr_len word window.
  function automatic logic in_window(input logic [15:0] addr, input int unsigned addr_len);
    if (addr_len >= 16) begin
      return 1'b1;
    end
    return ((addr >> addr_len) == 16'd0);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: combinational grant selection for the two-port mem_data arbiter.
// The tie-break winner is supplied by the top (round-robin pointer or fixed core priority).
module mem_arb_select
  import mem_arb_pkg::*;
(
  input  logic [MEM_ARB_NUM_PORTS-1:0] valid,
  input  logic [MEM_ARB_NUM_PORTS-1:0] lock,
  input  logic                         lock_active,
  input  port_id_t                     lock_owner,
  input  logic                         lock_expired,
  input  port_id_t                     tie_winner,
  output port_id_t                     grant,
  output logic                         grant_any
);

  port_id_t other;
  logic     held;

  // Owner keeps the grant while it still wants it; an expired lock hands over to a waiting port.
  always_comb begin
    grant     = PORT_CORE;
    grant_any = |valid;
    other     = port_id_t'(~lock_owner);
    held      = lock_active && valid[lock_owner] && lock[lock_owner] && !lock_expired;
    if (held) begin
      grant = lock_owner;
    end else if (lock_expired && valid[other]) begin
      grant = other;
    end else if (&valid) begin
      grant = tie_winner;
    end else if (valid[PORT_AUX]) begin
      grant = PORT_AUX;
    end
  end

endmodule

// File: rtl/mem_data_arbiter.sv
// mem_data_arbiter: shares one single-port mem_data between the core port (0) and an
// auxiliary port (1). One access per cycle, address-window enforcement, bounded locking,
// one-cycle registered read valid.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise port 0 wins ties.
module mem_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned p_WORD_LEN = 16,
  parameter int unsigned p_ADDR_LEN = 10,
  parameter int unsigned p_LOCK_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req0_valid,
  input  logic                  i_req0_wr_en,
  input  logic [15:0]           i_req0_addr,
  input  logic [p_WORD_LEN-1:0] i_req0_wr_data,
  input  logic                  i_req0_lock,
  output logic                  o_req0_ready,
  output logic                  o_req0_rd_valid,
  output logic [p_WORD_LEN-1:0] o_req0_rd_data,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_wr_en,
  input  logic [15:0]           i_req1_addr,
  input  logic [p_WORD_LEN-1:0] i_req1_wr_data,
  input  logic                  i_req1_lock,
  output logic                  o_req1_ready,
  output logic                  o_req1_rd_valid,
  output logic [p_WORD_LEN-1:0] o_req1_rd_data,
  output logic                  o_mem_wr_en,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

  localparam int unsigned CNT_W = $clog2(p_LOCK_MAX + 1);

  logic [MEM_ARB_NUM_PORTS-1:0] valid;
  logic [MEM_ARB_NUM_PORTS-1:0] lock;
  port_id_t                     grant;
  logic                         grant_any;
  port_id_t                     tie_winner;

  logic                         lock_active, lock_active_n;
  port_id_t                     lock_owner, lock_owner_n;
  logic [CNT_W-1:0]             lock_cnt, lock_cnt_n;
  logic                         lock_expired;
  logic                         other_valid;

  logic                         sel_wr_en;
  logic [15:0]                  sel_addr;
  logic [p_WORD_LEN-1:0]        sel_wr_data;
  logic                         sel_lock;
  logic                         sel_in_window;

  logic                         rd_pend;
  port_id_t                     rd_port;
  logic                         rd_oob;
  logic [p_WORD_LEN-1:0]        ret_data;
  logic [p_WORD_LEN-1:0]        rd_hold0, rd_hold1;

  assign valid = {i_req1_valid, i_req0_valid};
  assign lock  = {i_req1_lock, i_req0_lock};

  assign lock_expired = lock_active && (lock_cnt == CNT_W'(p_LOCK_MAX));

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_id_t rr_ptr;

  // Pointer moves to the non-granted port after every grant made without a lock request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= PORT_CORE;
    end else if (grant_any && !sel_lock) begin
      rr_ptr <= port_id_t'(~grant);
    end
  end

  assign tie_winner = rr_ptr;
`else
  assign tie_winner = PORT_CORE;
`endif

  mem_arb_select u_select (
    .valid        (valid),
    .lock         (lock),
    .lock_active  (lock_active),
    .lock_owner   (lock_owner),
    .lock_expired (lock_expired),
    .tie_winner   (tie_winner),
    .grant        (grant),
    .grant_any    (grant_any)
  );

  assign o_req0_ready = grant_any && (grant == PORT_CORE);
  assign o_req1_ready = grant_any && (grant == PORT_AUX);

  // Steer the accepted request's fields; everything reads as zero when idle.
  always_comb begin
    sel_wr_en   = 1'b0;
    sel_addr    = '0;
    sel_wr_data = '0;
    sel_lock    = 1'b0;
    if (grant_any) begin
      if (grant == PORT_AUX) begin
        sel_wr_en   = i_req1_wr_en;
        sel_addr    = i_req1_addr;
        sel_wr_data = i_req1_wr_data;
        sel_lock    = i_req1_lock;
      end else begin
        sel_wr_en   = i_req0_wr_en;
        sel_addr    = i_req0_addr;
        sel_wr_data = i_req0_wr_data;
        sel_lock    = i_req0_lock;
      end
    end
  end

  assign sel_in_window = in_window(sel_addr, p_ADDR_LEN);
  assign o_mem_wr_en   = grant_any && sel_wr_en && sel_in_window;
  assign o_mem_addr    = sel_addr[p_ADDR_LEN-1:0];
  assign o_mem_wr_data = sel_wr_data;

  assign other_valid = valid[~grant];

  // Lock bookkeeping: an unlocked grant, an idle cycle or an owner change restarts the count.
  always_comb begin
    lock_active_n = 1'b0;
    lock_owner_n  = PORT_CORE;
    lock_cnt_n    = '0;
    if (grant_any && sel_lock) begin
      lock_active_n = 1'b1;
      lock_owner_n  = grant;
      if (lock_active && (lock_owner == grant)) begin
        lock_cnt_n = lock_cnt;
      end
      if (other_valid) begin
        lock_cnt_n = lock_cnt_n + CNT_W'(1);
      end
    end
  end

  // Lock state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lock_active <= 1'b0;
      lock_owner  <= PORT_CORE;
      lock_cnt    <= '0;
    end else begin
      lock_active <= lock_active_n;
      lock_owner  <= lock_owner_n;
      lock_cnt    <= lock_cnt_n;
    end
  end

  // Remember an accepted read so its data can be returned to the right port next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_pend <= 1'b0;
      rd_port <= PORT_CORE;
      rd_oob  <= 1'b0;
    end else begin
      rd_pend <= grant_any && !sel_wr_en;
      rd_port <= grant;
      rd_oob  <= !sel_in_window;
    end
  end

  assign ret_data        = rd_oob ? '0 : i_mem_rd_data;
  assign o_req0_rd_valid = rd_pend && (rd_port == PORT_CORE);
  assign o_req1_rd_valid = rd_pend && (rd_port == PORT_AUX);

  // Capture returned data so each port's rd_data holds until its next return.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_hold0 <= '0;
      rd_hold1 <= '0;
    end else begin
      if (o_req0_rd_valid) rd_hold0 <= ret_data;
      if (o_req1_rd_valid) rd_hold1 <= ret_data;
    end
  end

  // The return cycle shows the memory data directly; the hold register covers later cycles.
  assign o_req0_rd_data = o_req0_rd_valid ? ret_data : rd_hold0;
  assign o_req1_rd_data = o_req1_rd_valid ? ret_data : rd_hold1;

endmodule
